// File: rtl/rv_xbus_pkg.sv
// rtl/rv_xbus_pkg.sv - shared xbus widths, fetch FSM states and fetch buffer entry type
package rv_xbus_pkg;

   localparam int         XLEN        = 32;
   localparam logic [3:0] XBUS_BE_ALL = 4'hF;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small flushable FIFO of fetch entries with registered head
module fetch_fifo
   import rv_xbus_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         head_valid_o,
   output fetch_entry_t head_data_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_en;
   logic          pop_en;
   logic          full;

   // A flush discards any same-cycle write; the head is consumed by the flush anyway.
   assign push_en = push_i & ~flush_i;
   assign pop_en  = pop_i & (count_q != '0);
   assign full    = (count_q == CW'(DEPTH));

   assign head_valid_o = (count_q != '0);
   assign head_data_o  = mem_q[rptr_q];
   assign count_o      = count_q;

   // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_en) wptr_d = wptr_q + AW'(1);
         if (pop_en)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(push_en) - CW'(pop_en);
      end
   end

   // Storage and pointer registers; storage is cleared so an empty head reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) mem_q[wptr_q] <= push_data_i;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_en && !pop_en && full));

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch front end: sequential xbus reads into a decode-facing FIFO
module ifu_fetch
   import rv_xbus_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            xbus_cs,
   output logic            xbus_we,
   output logic [3:0]      xbus_be,
   output logic [XLEN-1:0] xbus_addr,
   output logic [XLEN-1:0] xbus_wdata,
   input  logic [XLEN-1:0] xbus_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CW1 = CW + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            issue;
   logic            deq;
   logic            push;
   logic [CW-1:0]   fifo_count;
   logic [CW1-1:0]  credits_used;
   logic [CW1-1:0]  credits_avail;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   // A request may only go out if its word is guaranteed a FIFO slot when it returns.
   assign deq           = inst_valid & inst_ready;
   assign credits_used  = {1'b0, fifo_count} + CW1'(inflight_q);
   assign credits_avail = CW1'(FIFO_DEPTH) + CW1'(deq);

   // Returning word is captured unless a redirect makes it stale.
   assign push       = inflight_q & ~redirect_valid;
   assign push_entry = '{pc: req_pc_q, inst: xbus_rdata};

   assign xbus_cs    = issue;
   assign xbus_we    = 1'b0;
   assign xbus_be    = XBUS_BE_ALL;
   assign xbus_addr  = pc_q;
   assign xbus_wdata = '0;

   assign inst_pc    = head_entry.pc;
   assign inst_data  = head_entry.inst;

   // FSM next state, issue decision and fetch PC update.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      issue      = 1'b0;
      case (state_q)
         IDLE:    if (fetch_en)  state_d = FETCH;
         FETCH:   if (!fetch_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q == FETCH) && fetch_en && !redirect_valid && (credits_used < credits_avail))
         issue = 1'b1;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~32'h3;
      end else if (issue) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
      end
      inflight_d = issue;
   end

   // Fetch state, PC and outstanding-request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_data_i  (push_entry),
      .pop_i        (deq),
      .flush_i      (redirect_valid),
      .head_valid_o (inst_valid),
      .head_data_o  (head_entry),
      .count_o      (fifo_count)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_ready;

   logic        a_cs, a_we, a_inst_valid;
   logic [3:0]  a_be;
   logic [31:0] a_addr, a_wdata, a_rdata, a_inst_data, a_inst_pc;
   logic        b_cs, b_we, b_inst_valid;
   logic [3:0]  b_be;
   logic [31:0] b_addr, b_wdata, b_rdata, b_inst_data, b_inst_pc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        cs;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ipc;
   } vec_t;

   vec_t vq[$];

   logic [31:0] exp_issue, exp_deliv, prev_pc, prev_data, rpc_r;
   logic        prev_hold, prev_rv, fe_r, rdy_r, rv_r;
   int          ndel;
   int          waited;
   bit          seen;

   ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .xbus_cs(a_cs), .xbus_we(a_we), .xbus_be(a_be), .xbus_addr(a_addr),
      .xbus_wdata(a_wdata), .xbus_rdata(a_rdata),
      .inst_valid(a_inst_valid), .inst_ready(inst_ready),
      .inst_data(a_inst_data), .inst_pc(a_inst_pc)
   );

   ifu_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .xbus_cs(b_cs), .xbus_we(b_we), .xbus_be(b_be), .xbus_addr(b_addr),
      .xbus_wdata(b_wdata), .xbus_rdata(b_rdata),
      .inst_valid(b_inst_valid), .inst_ready(inst_ready),
      .inst_data(b_inst_data), .inst_pc(b_inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a >> 2) * 32'h11;
   endfunction

   // Boot ROM: data one cycle after cs, garbage otherwise.
   always @(posedge clk) begin
      a_rdata <= a_cs ? rom(a_addr) : $urandom;
      b_rdata <= b_cs ? rom(b_addr) : $urandom;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
      fetch_en       = fe;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   task automatic add(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic cs, input logic [31:0] addr, input logic vld, input logic [31:0] ipc);
      vec_t v;
      v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.cs = cs; v.addr = addr; v.vld = vld; v.ipc = ipc;
      vq.push_back(v);
   endtask

   initial begin
      // Directed cycle-by-cycle vectors starting from reset release (RESET_PC=0).
      add(1,1,0,0,            0,32'h00,       0,0);
      add(1,1,0,0,            1,32'h00,       0,0);
      add(1,1,0,0,            1,32'h04,       0,0);
      add(1,1,0,0,            1,32'h08,       1,32'h00);
      add(1,1,0,0,            1,32'h0C,       1,32'h04);
      for (int i = 0; i < 10; i++)
         add(1,0,0,0,         0,32'h10,       1,32'h08);
      add(1,1,0,0,            1,32'h10,       1,32'h08);
      add(1,1,0,0,            1,32'h14,       1,32'h0C);
      add(1,1,0,0,            1,32'h18,       1,32'h10);
      add(1,0,1,32'h40,       0,32'h1C,       1,32'h14);
      add(1,0,0,0,            1,32'h40,       0,0);
      add(1,0,0,0,            1,32'h44,       0,0);
      add(1,0,0,0,            0,32'h48,       1,32'h40);
      add(1,1,0,0,            1,32'h48,       1,32'h40);
      add(1,1,0,0,            1,32'h4C,       1,32'h44);
      add(0,1,0,0,            0,32'h50,       1,32'h48);
      add(0,1,0,0,            0,32'h50,       1,32'h4C);
      for (int i = 0; i < 3; i++)
         add(0,1,0,0,         0,32'h50,       0,0);
      add(1,1,0,0,            0,32'h50,       0,0);
      add(1,1,0,0,            1,32'h50,       0,0);
      add(1,1,1,32'h43,       0,32'h54,       0,0);
      add(1,1,1,32'hFFFFFFFC, 0,32'h40,       0,0);
      add(1,1,0,0,            1,32'hFFFFFFFC, 0,0);
      add(1,1,0,0,            1,32'h00,       0,0);
      add(1,1,0,0,            1,32'h04,       1,32'hFFFFFFFC);
      add(1,1,0,0,            1,32'h08,       1,32'h00);

      // Reset values.
      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs",     {31'b0, a_cs},         0);
      check("rst_addr",   a_addr,                0);
      check("rst_addr_b", b_addr,                32'h100);
      check("rst_valid",  {31'b0, a_inst_valid}, 0);
      check("rst_data",   a_inst_data,           0);
      check("rst_pc",     a_inst_pc,             0);
      check("rst_we",     {31'b0, a_we},         0);
      check("rst_be",     {28'b0, a_be},         32'hF);
      check("rst_wdata",  a_wdata,               0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table-driven directed sequence.
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].fe, vq[i].rdy, vq[i].rv, vq[i].rpc);
         @(negedge clk);
         check($sformatf("row%0d_cs", i),    {31'b0, a_cs},         {31'b0, vq[i].cs});
         check($sformatf("row%0d_addr", i),  a_addr,                vq[i].addr);
         check($sformatf("row%0d_valid", i), {31'b0, a_inst_valid}, {31'b0, vq[i].vld});
         if (vq[i].vld) begin
            check($sformatf("row%0d_ipc", i),  a_inst_pc,   vq[i].ipc);
            check($sformatf("row%0d_data", i), a_inst_data, rom(vq[i].ipc));
         end
         @(posedge clk); #1;
      end

      // Random phase: resynchronise the model with a redirect, then check against a stream model.
      drive(1, 0, 1, 32'h200);
      @(posedge clk); #1;
      exp_issue = 32'h200;
      exp_deliv = 32'h200;
      prev_hold = 1'b0;
      prev_rv   = 1'b1;
      ndel      = 0;
      for (int c = 0; c < 3000; c++) begin
         fe_r  = ($urandom_range(0, 9) < 8);
         rdy_r = ($urandom_range(0, 9) < 6);
         rv_r  = ($urandom_range(0, 15) == 0);
         rpc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                             : (32'h1000 + ($urandom & 32'hFFF));
         drive(fe_r, rdy_r, rv_r, rpc_r);
         @(negedge clk);
         if (a_cs) begin
            check("rnd_cs_gate", {30'b0, ~fe_r, rv_r}, 0);
            check("rnd_issue_addr", a_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
         end
         if (prev_rv)
            check("rnd_flush_valid", {31'b0, a_inst_valid}, 0);
         if (prev_hold) begin
            check("rnd_hold_valid", {31'b0, a_inst_valid}, 1);
            check("rnd_hold_pc",    a_inst_pc,             prev_pc);
            check("rnd_hold_data",  a_inst_data,           prev_data);
         end
         if (a_inst_valid && rdy_r) begin
            check("rnd_deliv_pc",   a_inst_pc,   exp_deliv);
            check("rnd_deliv_data", a_inst_data, rom(exp_deliv));
            exp_deliv = exp_deliv + 32'd4;
            ndel++;
         end
         if (rv_r) begin
            exp_issue = rpc_r & ~32'h3;
            exp_deliv = rpc_r & ~32'h3;
         end
         prev_hold = a_inst_valid && !rdy_r && !rv_r;
         prev_rv   = rv_r;
         prev_pc   = a_inst_pc;
         prev_data = a_inst_data;
         @(posedge clk); #1;
      end
      check("rnd_min_deliveries", {31'b0, (ndel > 300)}, 1);

      // Asynchronous reset in the middle of a burst.
      drive(1, 1, 0, 0);
      repeat (5) @(posedge clk);
      #2;
      check("burst_valid_before_rst", {31'b0, a_inst_valid}, 1);
      rst_n = 1'b0;
      #1;
      check("arst_cs",      {31'b0, a_cs},         0);
      check("arst_addr",    a_addr,                0);
      check("arst_valid",   {31'b0, a_inst_valid}, 0);
      check("arst_data",    a_inst_data,           0);
      check("arst_pc",      a_inst_pc,             0);
      check("arst_addr_b",  b_addr,                32'h100);
      check("arst_valid_b", {31'b0, b_inst_valid}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen   = 1'b0;
      waited = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (b_cs) begin
            seen = 1'b1;
            check("post_rst_first_addr_b", b_addr, 32'h100);
            check("post_rst_first_cycle_b", waited, 1);
         end
         waited++;
         @(posedge clk); #1;
      end
      check("post_rst_cs_seen", {31'b0, seen}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
